stream_serializer: RTL and testbench
====================================

Name: stream_serializer

Overview:
- Width-down converter for the valid/ready stream fabric. It sits downstream of the wide stream_register / register_skid_buffer stages.
- Accepts one N*DW-bit word per input handshake and emits it as N consecutive DW-bit beats on a narrow valid/ready output.
- The last beat is flagged with last_o.
- It is the transmit-side counterpart of a deserializer. Used where a wide internal pipeline drives a narrow link or port.

Parameters:
- DW, 8, width of one output lane in bits
- N, 4, lanes per input word; N >= 2 required (elaboration error otherwise)
- CW, $clog2(N), lane counter width (derived, not overridable)

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- clear_i  input  1  synchronous flush; drops any held word
- valid_i  input  1  input word valid
- ready_o  output  1  serializer can accept a word this cycle
- data_i  input  N*DW  input word; lane k = data_i[k*DW +: DW]
- valid_o  output  1  output beat valid
- ready_i  input  1  downstream accepts beat
- data_o  output  DW  current output lane
- last_o  output  1  current beat is the final lane of its word

Behaviour:
- Reset values: valid_o=0, last_o=0, data_o=0, ready_o=1. Held word register and lane counter cnt_q also reset to 0.
- Handshakes:
  - Input handshake: in_hs = valid_i & ready_o.
  - Output handshake: out_hs = valid_o & ready_i.
- FSM has two states:
  - IDLE (valid_o=0): ready_o=1. On in_hs, go to SEND, capture data_i, set cnt_q=0.
  - SEND (valid_o=1): data_o = held lane cnt_q; last_o = (cnt_q == N-1).
  - SEND, on out_hs with last_o=0: cnt_q increments and the state is held.
  - SEND, on out_hs with last_o=1 and valid_i=1: the new word is captured in the same cycle, cnt_q=0, and the state stays SEND (no bubble).
  - SEND, on out_hs with last_o=1 and valid_i=0: go to IDLE.
- ready_o = IDLE | (SEND & last_o & ready_i). This is a combinational path from ready_i; it is intentional for full throughput.
- Latency: the first beat appears on valid_o the cycle after in_hs.
- Throughput: N output beats per word. Sustained 100% output utilisation when valid_i and ready_i are both held high.
- Stall: while valid_o=1 and ready_i=0, data_o, last_o and cnt_q stay stable. valid_o must not drop without out_hs (AXI-style rule).
- data_i is sampled only on in_hs. Changes at other times have no effect.
- Counter never wraps past N-1. The transition from N-1 to 0 happens only together with a word reload.
- clear_i:
  - Next cycle: IDLE, valid_o=0, cnt_q=0.
  - Overrides a simultaneous in_hs (the word is dropped) and a simultaneous out_hs.
  - ready_o still reflects the pre-clear state combinationally.
- Reset asserted mid-word: all state returns to reset values immediately. The partial word is lost and no last_o is emitted.
- data_o in IDLE holds its last value. Consumers must ignore it when valid_o=0.

Optional Feature:
- Macro: STREAM_SERIALIZER_MSB_FIRST_EN.
- Defined: lanes are emitted from N-1 down to 0, i.e. data_o = lane (N-1-cnt_q). last_o is still asserted on the Nth beat.
- Undefined (default): lane 0 (LSBs) is emitted first.
- Handshake timing is identical in both builds.

Decomposition:
- stream_pkg holds a state enum type, ser_state_e {SER_IDLE, SER_SEND}.
- stream_pkg also holds the lane-index helper function (natural or reversed order), so a later deserializer uses the same ordering.
- No sub-module. The lane mux and counter are small enough to live inline.
- Output timing is register-based. Callers needing a registered ready_o place register_skid_buffer on the input side.

Test Plan:
- Single word, DW=8, N=4: data_i=0xDDCCBBAA, ready_i=1 -> data_o = AA, BB, CC, DD on four consecutive cycles; last_o only on DD; ready_o=0 during the AA..CC beats.
- Back-to-back: 0x03020100 then 0x07060504, valid_i and ready_i held high -> 8 contiguous beats 00..07 with no bubble; second word accepted in the cycle DD-equivalent 03 is taken.
- Backpressure: ready_i low for 3 cycles during beat BB -> data_o=BB, valid_o=1, last_o=0 held stable until ready_i rises.
- Random ready_i (urandom) with 50 random words -> scoreboard matches lane order and exactly one last_o per word.
- clear_i pulsed during beat CC -> valid_o=0 next cycle, no DD emitted; next word 0x44332211 emits 11 first.
- rst_ni pulsed low during beat BB -> valid_o drops asynchronously, ready_o=1. With STREAM_SERIALIZER_MSB_FIRST_EN defined, 0xDDCCBBAA emits DD, CC, BB, AA.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and lane ordering for the stream width converters, so the
// serializer and a future deserializer agree on which lane goes first.
package stream_pkg;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_e;

    // Lane emitted on a given beat: natural (LSB lane first) or reversed order.
    function automatic int unsigned ser_lane(input int unsigned beat,
                                             input int unsigned n,
                                             input bit          msb_first);
        return msb_first ? (n - 1 - beat) : beat;
    endfunction

endpackage

// File: rtl/stream_serializer.sv
// Width-down converter: one N*DW-bit word in, N DW-bit beats out with last_o on the final beat.
// Build option STREAM_SERIALIZER_MSB_FIRST_EN emits the top lane first.
module stream_serializer
    import stream_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [N*DW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o,
    output logic          last_o
);

    localparam int unsigned   CW       = $clog2(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    if (N < 2) begin : g_bad_n
        $error("stream_serializer: N must be >= 2");
    end

    ser_state_e             state_q;
    logic [CW-1:0]          cnt_q;
    logic [N-1:0][DW-1:0]   word_q;
    logic [N-1:0][DW-1:0]   din;
    logic [DW-1:0]          data_q;
    logic                   last_q;
    logic [CW-1:0]          cnt_nxt;

    function automatic logic [CW-1:0] lane_of(input logic [CW-1:0] beat);
        return CW'(ser_lane(32'(beat), N, MSB_FIRST));
    endfunction

    assign din     = data_i;
    assign cnt_nxt = cnt_q + CW'(1);

    assign valid_o = (state_q == SER_SEND);
    assign data_o  = data_q;
    assign last_o  = last_q;
    // Combinational from ready_i so a new word can be taken on the final beat.
    assign ready_o = (state_q == SER_IDLE) | ((state_q == SER_SEND) & last_q & ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                SER_IDLE: begin
                    if (valid_i) begin
                        state_q <= SER_SEND;
                        word_q  <= din;
                        cnt_q   <= '0;
                        data_q  <= din[lane_of('0)];
                        last_q  <= 1'b0;
                    end
                end
                SER_SEND: begin
                    if (ready_i) begin
                        if (!last_q) begin
                            cnt_q  <= cnt_nxt;
                            data_q <= word_q[lane_of(cnt_nxt)];
                            last_q <= (cnt_nxt == LAST_CNT);
                        end else if (valid_i) begin
                            // Reload on the final beat: no bubble between words.
                            word_q <= din;
                            cnt_q  <= '0;
                            data_q <= din[lane_of('0)];
                            last_q <= 1'b0;
                        end else begin
                            state_q <= SER_IDLE;
                            cnt_q   <= '0;
                            last_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= SER_IDLE;
                    cnt_q   <= '0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Scoreboard bench for stream_serializer: words accepted push their expected beats,
// a negedge monitor pops and compares every output handshake.
module tb_stream_serializer;

    localparam int DW = 8;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          valid_i;
    logic          ready_o;
    logic [N*DW-1:0] data_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_o;
    logic          last_o;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    lasts_seen = 0;
    bit    rand_done = 0;

    always #5 clk = ~clk;

    stream_serializer #(.DW(DW), .N(N)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .last_o  (last_o)
    );

    // Reference: which byte of the word appears on beat k.
    function automatic logic [DW-1:0] exp_lane(input logic [N*DW-1:0] w, input int k);
        logic [N*DW-1:0] t;
        t = w;
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
        t = t >> ((N - 1 - k) * DW);
`else
        t = t >> (k * DW);
`endif
        return t[DW-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor / scoreboard
    logic          stall_prev = 1'b0;
    logic [DW-1:0] pd;
    logic          pl;
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", {31'b0, valid_o}, 32'd1);
                chk("stall_data", {24'b0, data_o}, {24'b0, pd});
                chk("stall_last", {31'b0, last_o}, {31'b0, pl});
            end
            if (clear_i) begin
                exp_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got beat %h expected none", data_o);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        chk("sb_data", {24'b0, data_o}, {24'b0, e.data});
                        chk("sb_last", {31'b0, last_o}, {31'b0, e.last});
                        if (last_o) lasts_seen++;
                    end
                end
                if (valid_i && ready_o) begin
                    for (int k = 0; k < N; k++)
                        exp_q.push_back('{data: exp_lane(data_i, k), last: (k == N - 1)});
                end
                stall_prev = valid_o && !ready_i;
                pd = data_o;
                pl = last_o;
            end
        end
    end

    task automatic send_word(input logic [N*DW-1:0] w, input bit keep);
        int t;
        valid_i = 1'b1;
        data_i  = w;
        t = 0;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got ready_o=0 expected 1 within 200 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            valid_i = 1'b0;
            data_i  = $urandom;
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (!valid_o && exp_q.size() == 0) break;
            t++;
            if (t > 500) break;
        end
        chk({name, "_drain_q"}, exp_q.size(), 32'd0);
        chk({name, "_drain_valid"}, {31'b0, valid_o}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N*DW-1:0] w1, w2;
        rst_ni  = 1'b0;
        clear_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;
        #12;
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_last", {31'b0, last_o}, 32'd0);
        chk("rst_data", {24'b0, data_o}, 32'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Single word, full-rate sink
        w1 = 32'hDDCCBBAA;
        send_word(w1, 0);
        for (int k = 0; k < N; k++) begin
            chk("single_valid", {31'b0, valid_o}, 32'd1);
            chk("single_data", {24'b0, data_o}, {24'b0, exp_lane(w1, k)});
            chk("single_last", {31'b0, last_o}, (k == N - 1) ? 32'd1 : 32'd0);
            chk("single_ready", {31'b0, ready_o}, (k == N - 1) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        chk("single_idle", {31'b0, valid_o}, 32'd0);
        drain("single");

        // Back-to-back words, no bubble
        w1 = 32'h03020100;
        w2 = 32'h07060504;
        send_word(w1, 1);
        data_i = w2;
        for (int i = 0; i < 2 * N; i++) begin
            chk("b2b_valid", {31'b0, valid_o}, 32'd1);
            chk("b2b_data", {24'b0, data_o}, {24'b0, exp_lane(i < N ? w1 : w2, i % N)});
            if (i == N - 1) chk("b2b_ready", {31'b0, ready_o}, 32'd1);
            if (i == N) valid_i = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("b2b_idle", {31'b0, valid_o}, 32'd0);
        drain("b2b");

        // Backpressure on beat 1
        w1 = 32'hDDCCBBAA;
        send_word(w1, 0);
        @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {31'b0, valid_o}, 32'd1);
            chk("bp_data", {24'b0, data_o}, {24'b0, exp_lane(w1, 1)});
            chk("bp_last", {31'b0, last_o}, 32'd0);
            chk("bp_ready_o", {31'b0, ready_o}, 32'd0);
        end
        ready_i = 1'b1;
        drain("bp");

        // Clear during beat 2
        send_word(w1, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("clr_pre_data", {24'b0, data_o}, {24'b0, exp_lane(w1, 2)});
        clear_i = 1'b1;
        @(posedge clk);
        #1 clear_i = 1'b0;
        chk("clr_valid", {31'b0, valid_o}, 32'd0);
        chk("clr_ready", {31'b0, ready_o}, 32'd1);
        w2 = 32'h44332211;
        send_word(w2, 0);
        chk("clr_next_first", {24'b0, data_o}, {24'b0, exp_lane(w2, 0)});
        drain("clr");

        // Async reset during beat 1
        send_word(w1, 0);
        @(posedge clk);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_valid", {31'b0, valid_o}, 32'd0);
        chk("arst_ready", {31'b0, ready_o}, 32'd1);
        chk("arst_last", {31'b0, last_o}, 32'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_after_valid", {31'b0, valid_o}, 32'd0);
        w2 = 32'h5A6B7C8D;
        send_word(w2, 0);
        chk("arst_next_first", {24'b0, data_o}, {24'b0, exp_lane(w2, 0)});
        drain("arst");

        // Random words with random backpressure
        lasts_seen = 0;
        fork
            begin
                for (int n = 0; n < 50; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send_word($urandom, 0);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 ready_i = $urandom_range(0, 1);
                end
                ready_i = 1'b1;
            end
        join
        drain("rand");
        chk("rand_lasts", lasts_seen, 32'd50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
